// File: rtl/newhope_pkg.sv
// rtl/newhope_pkg.sv - shared constants, FSM encoding and byte packing for the polynomial codec family
package newhope_pkg;

    localparam int Q          = 12289;
    localparam int N          = 512;
    localparam int COEFF_BITS = 14;
    localparam int POLY_BYTES = 896;
    localparam int GROUPS     = N / 4;

    typedef enum logic [3:0] {
        IDLE,
        RD0, RD1, RD2, RD3,
        CAP,
        WR0, WR1, WR2, WR3, WR4, WR5, WR6,
        FIN
    } state_t;

    // Byte k of a 4-coefficient group, coefficients laid down LSB-first as one 56-bit word.
    function automatic logic [7:0] pack_byte(
        input logic [2:0]            k,
        input logic [COEFF_BITS-1:0] t0,
        input logic [COEFF_BITS-1:0] t1,
        input logic [COEFF_BITS-1:0] t2,
        input logic [COEFF_BITS-1:0] t3
    );
        case (k)
            3'd0:    return t0[7:0];
            3'd1:    return {t1[1:0], t0[13:8]};
            3'd2:    return t1[9:2];
            3'd3:    return {t2[3:0], t1[13:10]};
            3'd4:    return t2[11:4];
            3'd5:    return {t3[5:0], t2[13:12]};
            3'd6:    return t3[13:6];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/coeff_freeze.sv
// rtl/coeff_freeze.sv - single conditional subtraction of Q bringing a 14-bit value into [0, Q)
module coeff_freeze
    import newhope_pkg::*;
(
    input  logic [COEFF_BITS-1:0] c,
    output logic [COEFF_BITS-1:0] t
);

    localparam logic [COEFF_BITS-1:0] Q_W = COEFF_BITS'(Q);

    // Inputs never exceed 2^14-1 < 2Q, so one subtraction is enough.
    assign t = (c >= Q_W) ? c - Q_W : c;

endmodule

// File: rtl/polynomial_encoder.sv
// rtl/polynomial_encoder.sv - packs 512 reduced 14-bit coefficients into 896 little-endian bytes
module polynomial_encoder
    import newhope_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [8:0]  poly_addr,
    input  logic [15:0] poly_do,
    output logic        byte_we,
    output logic [9:0]  byte_addr,
    output logic [7:0]  byte_di
);

    state_t                state;
    logic [6:0]            grp;
    logic [9:0]            wr_ptr;
    logic [COEFF_BITS-1:0] t0, t1, t2, t3;
    logic [COEFF_BITS-1:0] t_frz;
    logic                  wr_go;
    logic [2:0]            wr_k;
    logic                  unused_upper;

    assign unused_upper = ^poly_do[15:14];

    coeff_freeze u_freeze (
        .c (poly_do[COEFF_BITS-1:0]),
        .t (t_frz)
    );

    // The registered write for byte k is launched from the state preceding WRk.
    always_comb begin
        wr_go = 1'b1;
        wr_k  = 3'd0;
        case (state)
            CAP:     wr_k = 3'd0;
            WR0:     wr_k = 3'd1;
            WR1:     wr_k = 3'd2;
            WR2:     wr_k = 3'd3;
            WR3:     wr_k = 3'd4;
            WR4:     wr_k = 3'd5;
            WR5:     wr_k = 3'd6;
            default: wr_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grp       <= '0;
            wr_ptr    <= '0;
            t0        <= '0;
            t1        <= '0;
            t2        <= '0;
            t3        <= '0;
            done      <= 1'b0;
            poly_addr <= '0;
            byte_we   <= 1'b0;
            byte_addr <= '0;
            byte_di   <= '0;
        end else begin
            done      <= 1'b0;
            byte_we   <= 1'b0;
            byte_addr <= '0;
            byte_di   <= '0;

            if (wr_go) begin
                byte_we   <= 1'b1;
                byte_addr <= wr_ptr;
                byte_di   <= pack_byte(wr_k, t0, t1, t2, t3);
                wr_ptr    <= wr_ptr + 10'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RD0;
                        grp       <= '0;
                        wr_ptr    <= '0;
                        poly_addr <= '0;
                    end
                end
                RD0: begin
                    poly_addr <= {grp, 2'd1};
                    state     <= RD1;
                end
                RD1: begin
                    t0        <= t_frz;
                    poly_addr <= {grp, 2'd2};
                    state     <= RD2;
                end
                RD2: begin
                    t1        <= t_frz;
                    poly_addr <= {grp, 2'd3};
                    state     <= RD3;
                end
                RD3: begin
                    t2    <= t_frz;
                    state <= CAP;
                end
                CAP: begin
                    t3    <= t_frz;
                    state <= WR0;
                end
                WR0: state <= WR1;
                WR1: state <= WR2;
                WR2: state <= WR3;
                WR3: state <= WR4;
                WR4: state <= WR5;
                WR5: state <= WR6;
                WR6: begin
                    if (grp == 7'(GROUPS - 1)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        grp       <= grp + 7'd1;
                        poly_addr <= {grp + 7'd1, 2'd0};
                        state     <= RD0;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    wr_ptr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polynomial_encoder.sv
// tb/tb_polynomial_encoder.sv - randomized self-checking bench for polynomial_encoder
module tb_polynomial_encoder;
    import newhope_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [8:0]  poly_addr;
    logic [15:0] poly_do;
    logic        byte_we;
    logic [9:0]  byte_addr;
    logic [7:0]  byte_di;

    polynomial_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .poly_addr (poly_addr),
        .poly_do   (poly_do),
        .byte_we   (byte_we),
        .byte_addr (byte_addr),
        .byte_di   (byte_di)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [N];
    always @(posedge clk) poly_do <= mem[poly_addr];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_count, done_count, order_err, idle_err, first_we_cyc, last_addr;
    int img     [POLY_BYTES];
    int exp_img [POLY_BYTES];
    int pat_fff [7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_we) begin
            if (wr_count == 0) first_we_cyc = cyc;
            if (int'(byte_addr) <= last_addr) order_err++;
            img[byte_addr] = int'(byte_di);
            last_addr = int'(byte_addr);
            wr_count++;
        end else if (byte_addr != 10'd0 || byte_di != 8'd0) begin
            idle_err++;
        end
        if (done) done_count++;
    end

    task automatic check(input string tag, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic clear_monitor();
        wr_count     = 0;
        done_count   = 0;
        order_err    = 0;
        idle_err     = 0;
        first_we_cyc = -1;
        last_addr    = -1;
        for (int a = 0; a < POLY_BYTES; a++) img[a] = -1;
    endtask

    // Reference: reduce with %, treat each group as one 56-bit little-endian word.
    task automatic build_expected();
        for (int g = 0; g < GROUPS; g++) begin
            longint v;
            v = 0;
            for (int j = 0; j < 4; j++)
                v |= longint'(int'(mem[4*g+j] & 16'h3FFF) % Q) << (14*j);
            for (int k = 0; k < 7; k++)
                exp_img[7*g+k] = int'((v >> (8*k)) & 255);
        end
    endtask

    task automatic check_image(input string tag);
        build_expected();
        for (int a = 0; a < POLY_BYTES; a++)
            check($sformatf("%s byte %0d", tag, a), img[a], exp_img[a]);
    endtask

    task automatic check_loopback();
        for (int g = 0; g < GROUPS; g++) begin
            longint v;
            v = 0;
            for (int k = 0; k < 7; k++)
                v |= longint'(img[7*g+k] & 255) << (8*k);
            for (int j = 0; j < 4; j++)
                check($sformatf("loopback coeff %0d", 4*g+j), (v >> (14*j)) & 16'h3FFF, mem[4*g+j]);
        end
    endtask

    task automatic run_encode(input bit hold);
        int cycles;
        int s;
        clear_monitor();
        @(negedge clk);
        start  = 1'b1;
        s      = cyc;
        cycles = 0;
        while (cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (!hold) start = 1'b0;
            if (done) break;
        end
        check("start_to_done_cycles", cycles, 1537);
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        repeat (20) @(negedge clk);
        check("first_write_latency", first_we_cyc - s, 6);
        check("write_count", wr_count, POLY_BYTES);
        check("done_pulses", done_count, 1);
        check("addr_order_errors", order_err, 0);
        check("idle_output_nonzero", idle_err, 0);
        check("last_addr", last_addr, POLY_BYTES - 1);
    endtask

    initial begin
        pat_fff = '{8'hFE, 8'h8F, 8'hFF, 8'hE3, 8'hFF, 8'hF8, 8'h3F};
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 16'h0;
        clear_monitor();
        repeat (3) @(negedge clk);
        check("reset done", done, 0);
        check("reset byte_we", byte_we, 0);
        check("reset byte_addr", byte_addr, 0);
        check("reset byte_di", byte_di, 0);
        check("reset poly_addr", poly_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < N; i++) mem[i] = 16'h3FFF;
        run_encode(1'b0);
        check_image("all_3fff");
        for (int k = 0; k < 7; k++) begin
            check("all_3fff group0", img[k], pat_fff[k]);
            check("all_3fff group127", img[7*127+k], pat_fff[k]);
        end

        for (int i = 0; i < N; i++) mem[i] = 16'(i);
        run_encode(1'b0);
        check_image("ramp");
        check("ramp byte1", img[1], 8'h40);
        check("ramp byte3", img[3], 8'h20);
        check("ramp byte5", img[5], 8'h0C);
        check("ramp byte889", img[889], 8'hFC);

        for (int i = 0; i < N; i++) mem[i] = 16'h0;
        mem[0] = 16'(Q);
        mem[1] = 16'(Q - 1);
        run_encode(1'b0);
        check_image("bound_q");
        check("bound_q byte0", img[0], 8'h00);
        check("bound_q byte2", img[2], 8'h00);
        check("bound_q byte3", img[3], 8'h0C);

        mem[0] = 16'(Q - 1);
        mem[1] = 16'h0;
        run_encode(1'b0);
        check("bound_qm1 byte1", img[1], 8'h30);

        mem[0] = 16'hC001;
        run_encode(1'b0);
        check("upper_bits byte0", img[0], 8'h01);
        check("upper_bits byte1", img[1], 8'h00);

        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        run_encode(1'b0);
        check_image("random_full_range");

        begin
            int  n;
            int  saved;
            bit  hit;
            clear_monitor();
            @(negedge clk);
            start = 1'b1;
            hit   = 1'b0;
            n     = 0;
            while (n < 2000 && !hit) begin
                @(negedge clk);
                start = 1'b0;
                n++;
                if (byte_we && byte_addr == 10'(7*40+3)) hit = 1'b1;
            end
            check("reset_point_reached", hit, 1);
            rst = 1'b1;
            @(negedge clk);
            check("post_reset byte_we", byte_we, 0);
            saved = wr_count;
            check("writes_before_reset", saved, 7*40+4);
            @(negedge clk);
            rst = 1'b0;
            repeat (30) @(negedge clk);
            check("writes_after_reset", wr_count, saved);
            check("done_after_reset", done_count, 0);
        end
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, 16383));
        run_encode(1'b0);
        check_image("restart_after_reset");

        for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, Q - 1));
        run_encode(1'b1);
        check_image("start_held");

        for (int seed = 0; seed < 20; seed++) begin
            for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, Q - 1));
            run_encode(1'b0);
            check_loopback();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
